fp16_normalize_round: RTL and testbench

Post-add normalize/round stage of the half-precision (IEEE 754 binary16) adder. It consumes the raw 11-bit mantissa result, carry and sticky flag from the mantissa add/subtract stage, together with the larger operand's exponent and sign. It normalizes iteratively, one left shift per cycle, then rounds to nearest-even and packs the final 16-bit result. It sits between the mantissa operate stage and the result register, with valid/ready handshakes on both sides.

---
 rtl/fp16_pkg.sv | 34 +++
 rtl/fp16_normalize_round_if.sv | 35 +++
 rtl/fp16_round_pack.sv | 54 +++++
 rtl/fp16_normalize_round.sv | 149 ++++++++++++++
 tb/tb_fp16_normalize_round.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 constants, FSM state encoding and packed-result layout used
// by the adder's normalize/round stage.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int RM_W    = MAN_W + 1;
  localparam int EXP_MAX = 31;
  localparam int BIAS    = 15;

  localparam logic [15:0] INF_PAT = 16'h7C00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ROUND = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  // Another left shift is allowed only while the hidden bit is clear and the
  // exponent can still drop without going below the subnormal floor of 1.
  function automatic logic needs_shift(input logic [RM_W-1:0] m,
                                       input logic [EXP_W:0]  e);
    return !m[RM_W-1] && (e > 6'd1) && (m != '0);
  endfunction

endpackage

// File: rtl/fp16_normalize_round_if.sv
// Handshake and data bundle between the mantissa operate stage, this
// normalize/round stage and the result register.
interface fp16_normalize_round_if;
  import fp16_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [RM_W-1:0]  Rm;
  logic             carry;
  logic             arround;
  logic             moves_zero;
  logic             sub;
  logic [EXP_W-1:0] exp_in;
  logic             sign_in;

  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic             overflow;
  logic             underflow;
  logic             inexact;

  modport slave (
    input  in_valid, Rm, carry, arround, moves_zero, sub, exp_in, sign_in,
    input  out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact
  );

  modport master (
    output in_valid, Rm, carry, arround, moves_zero, sub, exp_in, sign_in,
    output out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact
  );

endinterface

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even and binary16 packing of a normalized
// 11-bit mantissa with a 6-bit exponent that may already exceed the range.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic [RM_W-1:0]  mant,
  input  logic [EXP_W:0]   exp,
  input  logic             sign,
  input  logic             guard,
  input  logic             sticky,
  output logic [15:0]      result,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact
);

  logic            round_up;
  logic [RM_W:0]   sum;
  logic [RM_W-1:0] mant_r;
  logic [EXP_W:0]  exp_r;
  fp16_t           pk;

  always_comb begin
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + {{RM_W{1'b0}}, round_up};

    // Rounding 0x7FF up carries out; renormalize to 1.0 in the next binade.
    if (sum[RM_W]) begin
      mant_r = {1'b1, {MAN_W{1'b0}}};
      exp_r  = exp + 6'd1;
    end else begin
      mant_r = sum[RM_W-1:0];
      exp_r  = exp;
    end

    pk        = '{sign: sign, exp: exp_r[EXP_W-1:0], man: mant_r[MAN_W-1:0]};
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = guard | sticky;

    if (exp_r >= 6'(EXP_MAX)) begin
      pk       = fp16_t'(INF_PAT);
      pk.sign  = sign;
      overflow = 1'b1;
      inexact  = 1'b1;
    end else if (!mant_r[RM_W-1]) begin
      pk.exp    = '0;
      underflow = (mant_r != '0) & (guard | sticky);
    end

    result = pk;
  end

endmodule

// File: rtl/fp16_normalize_round.sv
// Post-add normalize/round stage: one left shift per cycle, then RNE rounding
// and packing into binary16, with valid/ready handshakes on both sides.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | in_ready high, waiting for an operate-stage result
//   ST_PREP  | carry fold-in, cancellation negate, zero detect
//   ST_SHIFT | one normalizing left shift per cycle
//   ST_ROUND | round/pack evaluated, registered into the output
//   ST_OUT   | out_valid high, result held until out_ready
module fp16_normalize_round
  import fp16_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  fp16_normalize_round_if.slave   bus
);

  state_e          state;
  logic [RM_W-1:0] mant;
  logic [EXP_W:0]  exp;
  logic            sign;
  logic            guard;
  logic            sticky;
  logic            carry_q;
  logic            moves_zero_q;
  logic            sub_q;

  logic [15:0]     result_q;
  logic            overflow_q;
  logic            underflow_q;
  logic            inexact_q;

  logic [RM_W-1:0] mant_p;
  logic [EXP_W:0]  exp_p;
  logic            sign_p;
  logic            guard_p;
  logic [RM_W-1:0] mant_s;
  logic [EXP_W:0]  exp_s;

  logic [15:0]     rp_result;
  logic            rp_overflow;
  logic            rp_underflow;
  logic            rp_inexact;

  always_comb begin
    mant_p  = mant;
    exp_p   = exp;
    sign_p  = sign;
    guard_p = guard;

    if (!sub_q && carry_q && moves_zero_q) begin
      mant_p  = {1'b1, mant[RM_W-1:1]};
      guard_p = mant[0];
      exp_p   = exp + 6'd1;
    end else if (!sub_q && carry_q) begin
      // Unequal exponents: upstream already folded the carry into Rm.
      exp_p   = exp + 6'd1;
    end else if (sub_q && moves_zero_q && mant[RM_W-1]) begin
      mant_p  = (~mant) + 11'd1;
      sign_p  = ~sign;
    end

    if (mant_p == '0) begin
      sign_p = 1'b0;
      exp_p  = '0;
    end
  end

  assign mant_s = {mant[RM_W-2:0], 1'b0};
  assign exp_s  = exp - 6'd1;

  fp16_round_pack u_round_pack (
    .mant      (mant),
    .exp       (exp),
    .sign      (sign),
    .guard     (guard),
    .sticky    (sticky),
    .result    (rp_result),
    .overflow  (rp_overflow),
    .underflow (rp_underflow),
    .inexact   (rp_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mant         <= '0;
      exp          <= '0;
      sign         <= 1'b0;
      guard        <= 1'b0;
      sticky       <= 1'b0;
      carry_q      <= 1'b0;
      moves_zero_q <= 1'b0;
      sub_q        <= 1'b0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      inexact_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mant         <= bus.Rm;
            exp          <= {1'b0, bus.exp_in};
            sign         <= bus.sign_in;
            guard        <= 1'b0;
            sticky       <= bus.arround;
            carry_q      <= bus.carry;
            moves_zero_q <= bus.moves_zero;
            sub_q        <= bus.sub;
            state        <= ST_PREP;
          end
        end
        ST_PREP: begin
          mant  <= mant_p;
          exp   <= exp_p;
          sign  <= sign_p;
          guard <= guard_p;
          state <= needs_shift(mant_p, exp_p) ? ST_SHIFT : ST_ROUND;
        end
        ST_SHIFT: begin
          mant  <= mant_s;
          exp   <= exp_s;
          state <= needs_shift(mant_s, exp_s) ? ST_SHIFT : ST_ROUND;
        end
        ST_ROUND: begin
          result_q    <= rp_result;
          overflow_q  <= rp_overflow;
          underflow_q <= rp_underflow;
          inexact_q   <= rp_inexact;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.inexact   = inexact_q;

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Self-checking bench: directed test-plan vectors plus randomized traffic
// against an arithmetic reference model and a latency-aware scoreboard.
module tb_fp16_normalize_round;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp16_normalize_round_if bus();

  fp16_normalize_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic        ov;
    logic        uf;
    logic        ix;
    int          lat;
  } expect_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 1;
  expect_t sb_q[$];
  int acc_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value-level arithmetic on the mantissa as an integer.
  function automatic expect_t model(input logic [10:0] rm, input logic c, input logic ar,
                                    input logic mz, input logic sb, input logic [4:0] ei,
                                    input logic si);
    int m, e, g, s, sg, n, msb, v;
    expect_t r;
    m = rm; e = ei; g = 0; s = ar; sg = si; n = 0;
    if (!sb && c && mz) begin
      g = m % 2; m = m / 2 + 1024; e = e + 1;
    end else if (!sb && c) begin
      e = e + 1;
    end else if (sb && mz && m >= 1024) begin
      m = 2048 - m; sg = (sg == 0) ? 1 : 0;
    end
    if (m == 0) begin
      sg = 0; e = 0;
    end else begin
      msb = 0;
      for (int b = 0; b < 11; b++) if (((m >> b) & 1) == 1) msb = b;
      n = 10 - msb;
      if (n > e - 1) n = e - 1;
      m = m * (1 << n);
      e = e - n;
    end
    v = m + ((g == 1 && (s == 1 || m % 2 == 1)) ? 1 : 0);
    if (v == 2048) begin v = 1024; e = e + 1; end
    r.ix = (g | s) != 0;
    r.ov = 1'b0;
    r.uf = 1'b0;
    if (e >= 31) begin
      r.res = {sg[0], 15'h7C00}; r.ov = 1'b1; r.ix = 1'b1;
    end else if (v < 1024) begin
      r.res = {sg[0], 5'd0, v[9:0]};
      r.uf = (v != 0) && r.ix;
    end else begin
      r.res = {sg[0], e[4:0], v[9:0]};
    end
    r.lat = n + 2;
    return r;
  endfunction

  task automatic send(input logic [10:0] rm, input logic c, input logic ar, input logic mz,
                      input logic sb, input logic [4:0] ei, input logic si);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    bus.Rm = rm; bus.carry = c; bus.arround = ar; bus.moves_zero = mz;
    bus.sub = sb; bus.exp_in = ei; bus.sign_in = si; bus.in_valid = 1'b1;
    sb_q.push_back(model(rm, c, ar, mz, sb, ei, si));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 400) begin @(negedge clk); w++; end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
  endtask

  // out_ready changes just after the rising edge so negedge sampling is stable.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: bus.out_ready = 1'b0;
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Scoreboard compare: every cycle the output is valid.
  initial begin
    logic prev_valid;
    expect_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (sb_q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
          end else begin
            e = sb_q[0];
            if (!prev_valid) chk("latency", cyc - acc_q[0], e.lat);
            chk("result", bus.result, e.res);
            chk("overflow", bus.overflow, e.ov);
            chk("underflow", bus.underflow, e.uf);
            chk("inexact", bus.inexact, e.ix);
            chk("in_ready_busy", bus.in_ready, 0);
            if (bus.out_ready) begin
              void'(sb_q.pop_front());
              void'(acc_q.pop_front());
            end
          end
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    expect_t m;
    logic [15:0] held;
    int w;
    bus.in_valid = 1'b0; bus.Rm = '0; bus.carry = 1'b0; bus.arround = 1'b0;
    bus.moves_zero = 1'b0; bus.sub = 1'b0; bus.exp_in = 5'd1; bus.sign_in = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_flags", {bus.overflow, bus.underflow, bus.inexact}, 3'b000);
    rst_n = 1'b1;

    // Hand-computed literals pin the model.
    m = model(11'h000, 1, 0, 1, 0, 5'd15, 0);
    chk("pin_one_plus_one", {m.res, m.ov, m.uf, m.ix}, {16'h4000, 3'b000});
    chk("pin_one_plus_one_lat", m.lat, 2);
    m = model(11'h003, 1, 0, 1, 0, 5'd15, 0);
    chk("pin_rne_up", {m.res, m.ix}, {16'h4002, 1'b1});
    m = model(11'h001, 1, 0, 1, 0, 5'd15, 0);
    chk("pin_rne_even", {m.res, m.ix}, {16'h4000, 1'b1});
    m = model(11'h001, 0, 0, 1, 1, 5'd15, 0);
    chk("pin_cancel", m.res, 16'h1400);
    chk("pin_cancel_lat", m.lat, 12);
    m = model(11'h7FF, 0, 0, 1, 1, 5'd15, 0);
    chk("pin_cancel_neg", m.res, 16'h9400);
    m = model(11'h001, 0, 0, 1, 1, 5'd3, 0);
    chk("pin_sub_exact", {m.res, m.uf, m.ix}, {16'h0004, 2'b00});
    chk("pin_sub_lat", m.lat, 4);
    m = model(11'h001, 0, 1, 1, 1, 5'd3, 0);
    chk("pin_sub_inexact", {m.res, m.uf, m.ix}, {16'h0004, 2'b11});
    m = model(11'h400, 1, 0, 0, 0, 5'd30, 0);
    chk("pin_overflow", {m.res, m.ov, m.ix}, {16'h7C00, 2'b11});
    m = model(11'h000, 0, 0, 1, 1, 5'd9, 1);
    chk("pin_zero", m.res, 16'h0000);

    // Test-plan vectors through the DUT.
    rdy_mode = 1;
    send(11'h000, 1, 0, 1, 0, 5'd15, 0);
    send(11'h003, 1, 0, 1, 0, 5'd15, 0);
    send(11'h001, 1, 0, 1, 0, 5'd15, 0);
    send(11'h001, 0, 0, 1, 1, 5'd15, 0);
    send(11'h7FF, 0, 0, 1, 1, 5'd15, 0);
    send(11'h001, 0, 0, 1, 1, 5'd3, 0);
    send(11'h001, 0, 1, 1, 1, 5'd3, 0);
    send(11'h400, 1, 0, 0, 0, 5'd30, 0);
    send(11'h000, 0, 0, 1, 1, 5'd9, 1);
    send(11'h7FF, 1, 1, 1, 0, 5'd30, 1);
    drain();

    // Backpressure: outputs frozen while out_ready stays low.
    rdy_mode = 0;
    send(11'h000, 1, 0, 1, 0, 5'd15, 0);
    w = 0;
    while (!bus.out_valid && w < 50) begin @(negedge clk); w++; end
    chk("bp_reach_out", bus.out_valid, 1);
    held = bus.result;
    repeat (5) begin
      @(negedge clk);
      chk("bp_result_stable", bus.result, 16'h4000);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_valid_held", bus.out_valid, 1);
    end
    chk("bp_result_first", held, 16'h4000);
    rdy_mode = 1;
    drain();

    // Reset in the middle of a long normalization.
    send(11'h001, 0, 0, 1, 1, 5'd15, 0);
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    sb_q.delete();
    acc_q.delete();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_result", bus.result, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with random backpressure, then with none.
    rdy_mode = 2;
    repeat (300) begin
      send(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)),
           1'($urandom_range(0, 1)));
    end
    drain();
    rdy_mode = 1;
    repeat (100) begin
      send(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)),
           1'($urandom_range(0, 1)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
